mac_accum_stage: RTL and testbench
==================================

Name: mac_accum_stage

Overview:
- Downstream accumulation/control stage for the combinational `mac` unit (`out = in1*in2 + preResult`, LEN-bit operands, 2*LEN-bit result, overflow flag).
- Drives the mac's `preResult` input with a per-vector bias and sums the mac outputs over a vector of programmable length.
- Accumulation saturates at the signed 2*LEN-bit range.
- Delivers one dot-product result per vector over a valid/ready handshake to the next pipeline stage.

Parameters:
- LEN, 9, mac operand width; accumulator and result are 2*LEN bits.
- CNT_W, 8, width of the vector-length field and element counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a vector; honoured only in IDLE.
- vec_len  input  CNT_W  number of elements; sampled with start.
- bias  input  LEN  signed bias; sampled with start.
- in_valid  input  1  mac_out/mac_ovf are valid this cycle; upstream is presenting operands to the mac.
- in_ready  output  1  stage accepts an element this cycle.
- mac_out  input  2*LEN  signed mac result.
- mac_ovf  input  1  mac overflow flag for the current element.
- pre_result  output  LEN  drives mac preResult.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_data  output  2*LEN  signed accumulated result.
- res_ovf  output  1  sticky: saturation or mac overflow occurred during the vector.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-vector):
  - State goes to IDLE.
  - acc, cnt, latched length, latched bias, res_data and res_ovf all clear to 0.
  - in_ready=0, res_valid=0, busy=0, pre_result=0.
  - The partial vector is discarded.
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready=0; start is the only event honoured.
  - On start: latch vec_len and bias, acc:=0, cnt:=0, sticky ovf:=0.
  - If vec_len!=0, go to ACCUM.
  - If vec_len==0, go to OUT with res_data = sign-extended bias and res_ovf=0.
- ACCUM:
  - in_ready=1 (combinational from state).
  - Beat = in_valid & in_ready.
  - On each beat: acc := sat(acc + mac_out); ovf := ovf | mac_ovf | saturated; cnt := cnt+1.
  - Sum is computed at 2*LEN+1 bits; saturated when it exceeds 2^(2LEN-1)-1 or falls below -2^(2LEN-1), and clamps to that bound. For LEN=9 the bounds are 131071 / -131072.
  - pre_result = latched bias while cnt==0, else 0. The bias therefore enters exactly once, via the first element's mac_out.
  - Cycles with in_valid=0 change nothing.
  - On the beat where cnt==len-1: go to OUT with the final sum loaded into res_data and the final flag into res_ovf.
  - Latency: res_valid asserts the cycle after the last beat.
  - start is ignored.
- OUT:
  - res_valid=1; in_ready=0; pre_result=0.
  - res_data and res_ovf hold stable until res_valid & res_ready, after which the state returns to IDLE.
  - start in the same cycle as the handshake is ignored; a new start is accepted from the next cycle.
  - start during OUT is ignored.
- Outputs are registered except in_ready, res_valid and busy, which are state decodes. pre_result decodes from state and cnt.
- vec_len=2^CNT_W-1 is legal; cnt does not wrap before reaching the terminal count.

Test Plan:
- Basic dot product:
  - Stimulus: start with vec_len=3, bias=10; beats with mac operands (100,88), (32,-32), (-21,-231), so mac_out = 8810, -1024, 4851.
  - Required: pre_result=10 during the first beat only; res_valid one cycle after the third beat; res_data=12637; res_ovf=0.
- Gapped input:
  - Stimulus: same as the basic dot product, with in_valid low for 2 cycles between beats.
  - Required: identical result; cnt unchanged during gaps.
- Saturation:
  - Stimulus: vec_len=3, bias=0, three beats of mac_out=65025 (255*255).
  - Required: res_data=131071, res_ovf=1.
  - Repeat with -65025×3: res_data=-131072, res_ovf=1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles in OUT and pulse start.
  - Required: res_valid/res_data stable; start ignored; busy=1; IDLE one cycle after res_ready=1.
- Zero length:
  - Stimulus: start with vec_len=0, bias=-5.
  - Required: next cycle res_valid=1, res_data=-5 (sign-extended), res_ovf=0; in_ready never asserted.
- Reset mid-op:
  - Stimulus: assert reset after 1 of 3 beats, between clock edges.
  - Required: all outputs immediately 0 and state IDLE; a following vec_len=1 vector with mac_out=7 gives res_data=7.

Source files
------------

// File: rtl/mac_accum_stage.sv
// Accumulation/control stage behind a combinational MAC: injects a per-vector bias,
// sums a vector of MAC results with saturation and hands one result downstream.
module mac_accum_stage #(
    parameter int LEN   = 9,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   vec_len,
    input  logic [LEN-1:0]     bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*LEN-1:0]   mac_out,
    input  logic               mac_ovf,
    output logic [LEN-1:0]     pre_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*LEN-1:0]   res_data,
    output logic               res_ovf,
    output logic               busy
);
    localparam int W = 2 * LEN;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t           state;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [LEN-1:0]   bias_q;
    logic             ovf_q;

    logic [W:0]       sum_wide;
    logic             sat;
    logic [W-1:0]     sum_sat;
    logic             beat;
    logic             last;

    // One guard bit: the two top bits disagree exactly when the sum left the W-bit range.
    always_comb begin
        sum_wide = {acc[W-1], acc} + {mac_out[W-1], mac_out};
        sat      = sum_wide[W] ^ sum_wide[W-1];
        sum_sat  = sum_wide[W-1:0];
        if (sat) begin
            sum_sat = sum_wide[W] ? MIN_NEG : MAX_POS;
        end
    end

    assign in_ready   = (state == ACCUM);
    assign res_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign beat       = in_valid & in_ready;
    assign last       = (cnt == len_q - CNT_W'(1));
    assign pre_result = (state == ACCUM && cnt == '0) ? bias_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            bias_q   <= '0;
            ovf_q    <= 1'b0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= vec_len;
                        bias_q <= bias;
                        acc    <= '0;
                        cnt    <= '0;
                        ovf_q  <= 1'b0;
                        if (vec_len != '0) begin
                            state <= ACCUM;
                        end else begin
                            // Empty vector: the result is the bias alone.
                            state    <= OUT;
                            res_data <= {{LEN{bias[LEN-1]}}, bias};
                            res_ovf  <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum_sat;
                        ovf_q <= ovf_q | mac_ovf | sat;
                        cnt   <= cnt + CNT_W'(1);
                        if (last) begin
                            res_data <= sum_sat;
                            res_ovf  <= ovf_q | mac_ovf | sat;
                            state    <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accum_stage.sv
// Bench for mac_accum_stage: emulates the upstream MAC, predicts every output from
// integer arithmetic over the vector and checks each negative clock edge.
module tb_mac_accum_stage;
    localparam int LEN   = 9;
    localparam int CNT_W = 8;
    localparam longint SMAX = 131071;
    localparam longint SMIN = -131072;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [CNT_W-1:0]       vec_len = '0;
    logic [LEN-1:0]         bias = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [2*LEN-1:0] mac_out;
    logic                   mac_ovf = 1'b0;
    logic [LEN-1:0]         pre_result;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [2*LEN-1:0]       res_data;
    logic                   res_ovf;
    logic                   busy;

    logic signed [LEN-1:0]  op_a = '0;
    logic signed [LEN-1:0]  op_b = '0;
    logic signed [LEN-1:0]  pre_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Upstream combinational MAC: out = in1*in2 + preResult
    assign pre_s   = pre_result;
    assign mac_out = 18'(longint'(op_a) * longint'(op_b) + longint'(pre_s));

    mac_accum_stage #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .mac_out(mac_out), .mac_ovf(mac_ovf),
        .pre_result(pre_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
    );

    function automatic longint clamp(longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Reference: mode 0 idle, 1 collecting elements, 2 holding a result.
    int              m_mode;
    int              m_left;
    bit              m_first;
    longint          m_bias;
    longint          m_sum;
    bit              m_sticky;
    longint          m_rd;
    bit              m_ro;
    longint          elem_val;
    longint          next_sum;

    assign elem_val = longint'(op_a) * longint'(op_b) + (m_first ? m_bias : 64'sd0);
    assign next_sum = clamp(m_sum + elem_val);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_left <= 0; m_first <= 1'b0; m_bias <= 0;
            m_sum <= 0; m_sticky <= 1'b0; m_rd <= 0; m_ro <= 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_left   <= int'(vec_len);
                    m_bias   <= longint'($signed(bias));
                    m_sum    <= 0;
                    m_sticky <= 1'b0;
                    m_first  <= 1'b1;
                    if (vec_len == 0) begin
                        m_mode <= 2; m_rd <= longint'($signed(bias)); m_ro <= 1'b0;
                    end else begin
                        m_mode <= 1;
                    end
                end
                1: if (in_valid) begin
                    m_sum    <= next_sum;
                    m_sticky <= m_sticky | mac_ovf | (next_sum != m_sum + elem_val);
                    m_first  <= 1'b0;
                    m_left   <= m_left - 1;
                    if (m_left == 1) begin
                        m_mode <= 2;
                        m_rd   <= next_sum;
                        m_ro   <= m_sticky | mac_ovf | (next_sum != m_sum + elem_val);
                    end
                end
                default: if (res_ready) m_mode <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", longint'(in_ready), longint'(m_mode == 1));
        chk("res_valid", longint'(res_valid), longint'(m_mode == 2));
        chk("busy", longint'(busy), longint'(m_mode != 0));
        chk("pre_result", longint'($signed(pre_result)), (m_mode == 1 && m_first) ? m_bias : 64'sd0);
        chk("res_data", longint'($signed(res_data)), m_rd);
        chk("res_ovf", longint'(res_ovf), longint'(m_ro));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l, input int b);
        start = 1'b1; vec_len = CNT_W'(l); bias = LEN'(b);
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input int a, input int b, input bit ov);
        in_valid = 1'b1; op_a = LEN'(a); op_b = LEN'(b); mac_ovf = ov;
        tick();
        in_valid = 1'b0; mac_ovf = 1'b0;
        op_a = LEN'($urandom); op_b = LEN'($urandom);
    endtask

    task automatic get_result(input int delay, input bit pulse,
                              output longint data, output bit ovf);
        int k = 0;
        while (!res_valid && k < 50) begin tick(); k++; end
        chk("result_timeout", longint'(res_valid), 1);
        data = longint'($signed(res_data));
        ovf  = res_ovf;
        for (int i = 0; i < delay; i++) begin
            start   = pulse && (i == 2);
            vec_len = 8'd2;
            tick();
        end
        start = pulse;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic basic_vec(input int gaps, output longint d, output bit o);
        int av[3] = '{100, 32, -21};
        int bv[3] = '{88, -32, -231};
        do_start(3, 10);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) chk("pre_first_beat", longint'($signed(pre_result)), 10);
            if (i == 1) chk("pre_after_first", longint'($signed(pre_result)), 0);
            beat(av[i], bv[i], 1'b0);
            if (i < 2) repeat (gaps) tick();
        end
        chk("latency_valid", longint'(res_valid), 1);
        get_result(0, 1'b0, d, o);
    endtask

    initial begin
        longint d;
        bit o;
        int l;

        #12;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_res_data", longint'(res_data), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        basic_vec(0, d, o);
        chk("basic_data", d, 12637); chk("basic_ovf", longint'(o), 0);
        basic_vec(2, d, o);
        chk("gap_data", d, 12637); chk("gap_ovf", longint'(o), 0);

        do_start(3, 0);
        repeat (3) beat(255, 255, 1'b0);
        get_result(0, 1'b0, d, o);
        chk("sat_pos_data", d, 131071); chk("sat_pos_ovf", longint'(o), 1);

        do_start(3, 0);
        repeat (3) beat(255, -255, 1'b0);
        get_result(5, 1'b1, d, o);
        chk("sat_neg_data", d, -131072); chk("sat_neg_ovf", longint'(o), 1);
        chk("idle_after_hs", longint'(busy), 0);

        do_start(0, -5);
        chk("zero_valid", longint'(res_valid), 1);
        get_result(1, 1'b0, d, o);
        chk("zero_data", d, -5); chk("zero_ovf", longint'(o), 0);

        do_start(2, 3);
        beat(5, 6, 1'b1);
        beat(1, 1, 1'b0);
        get_result(0, 1'b0, d, o);
        chk("macovf_data", d, 34); chk("macovf_ovf", longint'(o), 1);

        do_start(3, 4);
        beat(9, 9, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_pre", longint'(pre_result), 0);
        chk("rst_data", longint'(res_data), 0);
        chk("rst_ovf", longint'(res_ovf), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        do_start(1, 0);
        beat(7, 1, 1'b0);
        get_result(0, 1'b0, d, o);
        chk("post_rst_data", d, 7);

        do_start(255, 1);
        for (int i = 0; i < 255; i++) beat(int'($urandom_range(0, 4)) - 2, 3, 1'b0);
        get_result(0, 1'b0, d, o);

        for (int v = 0; v < 40; v++) begin
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            do_start(l, int'($urandom_range(0, 511)));
            for (int i = 0; i < l; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                beat(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                     $urandom_range(0, 15) == 0);
            end
            get_result(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, d, o);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
